// File: rtl/system_pll_pkg.sv
// Shared definitions for the PLL reset sequencer and related clocking blocks.
package system_pll_pkg;

  localparam int RELOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  // Width of the shared phase counter: wide enough for the longest phase.
  // A floor of one bit keeps the counter legal when every phase is a single cycle.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/system_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module system_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/system_pll_reset_ctrl.sv
// Reset sequencer downstream of the system PLL: qualifies lock, releases the
// fabric reset, and restarts the PLL on lock loss or lock timeout.
module system_pll_reset_ctrl
  import system_pll_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  output logic                    pll_rst,
  output logic                    sys_reset_n,
  output logic                    pll_ok,
  output logic                    lock_lost,
  output logic [RELOCK_CNT_W-1:0] relock_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic                    locked_s;
  pll_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    pll_rst_q, sys_reset_n_q, pll_ok_q, lock_lost_q;
  logic                    lock_lost_d;
  logic                    restart;

  system_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  // Next-state, phase counter and restart bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    relock_d    = relock_q;
    lock_lost_d = 1'b0;
    restart     = 1'b0;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          restart = 1'b1;
        end
      end
      STABLE: begin
        // A bounce before lock is accepted just re-arms the lock wait.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Lock was accepted, so a drop here is a real loss and restarts the PLL.
        if (!locked_s) begin
          state_d = PLL_RST;
          restart = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = PLL_RST;
          restart     = 1'b1;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (restart && (relock_q != '1)) relock_d = relock_q + RELOCK_CNT_W'(1);
  end

  // State register with outputs decoded from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      relock_q      <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      pll_ok_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      relock_q      <= relock_d;
      pll_rst_q     <= (state_d == PLL_RST);
      sys_reset_n_q <= (state_d == RUN);
      pll_ok_q      <= (state_d == RUN);
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_reset_n  = sys_reset_n_q;
  assign pll_ok       = pll_ok_q;
  assign lock_lost    = lock_lost_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_system_pll_reset_ctrl.sv
// Bench for the PLL reset sequencer: directed scenarios plus randomized lock
// activity, all compared against a timestamp-based behavioural model.
module tb_system_pll_reset_ctrl;

  localparam int SS = 2;
  localparam int PR = 3;
  localparam int TO = 32;
  localparam int LS = 8;
  localparam int RH = 4;
  localparam int ACQ = SS + 1 + LS + RH;   // 15 edges lock-to-release
  localparam int LOSS = SS + 1;            // 3 edges drop-to-restart

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       pll_ok;
  logic       lock_lost;
  logic [7:0] relock_count;

  always #5 clk = ~clk;

  system_pll_reset_ctrl #(
    .SYNC_STAGES        (SS),
    .PLL_RST_CYCLES     (PR),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (LS),
    .RESET_HOLD_CYCLES  (RH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .pll_ok      (pll_ok),
    .lock_lost   (lock_lost),
    .relock_count(relock_count)
  );

  wire logic [11:0] dut_vec = {pll_rst, sys_reset_n, pll_ok, lock_lost, relock_count};
  localparam logic [11:0] RESET_VEC = 12'h800;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: lock qualification is one merged phase timed from its
  // entry edge; the synchroniser is a plain delay line.
  typedef enum int {M_RST, M_WAIT, M_QUAL, M_RUN} mphase_e;
  mphase_e ph = M_RST;
  int      cyc = 0;
  int      t_enter = 0;
  int      m_relock = 0;
  bit      m_lost = 1'b0;
  bit      mvalid = 1'b0;
  bit      dq[$];

  function automatic void go(input mphase_e p);
    ph      = p;
    t_enter = cyc;
  endfunction

  function automatic void bump();
    if (m_relock < 255) m_relock++;
  endfunction

  always @(posedge clk) begin
    bit in_s;
    int n;
    cyc++;
    if (reset_n === 1'b0) begin
      go(M_RST);
      m_relock = 0;
      m_lost   = 1'b0;
      dq.delete();
      for (int i = 0; i < SS; i++) dq.push_back(1'b0);
      mvalid = 1'b1;
    end else if (mvalid) begin
      in_s = dq.pop_front();
      dq.push_back(pll_locked);
      n = cyc - t_enter;
      m_lost = 1'b0;
      case (ph)
        M_RST:  if (n >= PR) go(M_WAIT);
        M_WAIT: begin
          if (in_s) go(M_QUAL);
          else if (n >= TO) begin go(M_RST); bump(); end
        end
        M_QUAL: begin
          if (!in_s) begin
            if (n <= LS) go(M_WAIT);
            else begin go(M_RST); bump(); end
          end else if (n == LS + RH) go(M_RUN);
        end
        M_RUN: begin
          if (!in_s) begin go(M_RST); bump(); m_lost = 1'b1; end
        end
        default: go(M_RST);
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid)
      check_eq("model", {20'd0, dut_vec},
               {20'd0, (ph == M_RST), (ph == M_RUN), (ph == M_RUN), m_lost, m_relock[7:0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return pll_ok;
      default: return sys_reset_n;
    endcase
  endfunction

  // Count edges until the selected output reaches lvl; -1 if the bound expires.
  task automatic wait_for(input int sel, input logic lvl, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sig(sel) !== lvl && n < max);
    if (sig(sel) !== lvl) n = -1;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (5) tick();
    check_eq("reset_vec", {20'd0, dut_vec}, {20'd0, RESET_VEC});

    // Clean start
    reset_n = 1'b1;
    wait_for(0, 1'b0, 50, n);
    check_eq("pll_rst_len", n, PR);
    pll_locked = 1'b1;
    wait_for(1, 1'b1, 100, n);
    check_eq("acquire_lat", n, ACQ);
    check_eq("sysrst_with_ok", sys_reset_n, 1'b1);
    check_eq("relock_clean", relock_count, 8'd0);

    // Loss in RUN, then re-lock
    pll_locked = 1'b0;
    wait_for(1, 1'b0, 20, n);
    check_eq("loss_lat", n, LOSS);
    check_eq("loss_sysrst", sys_reset_n, 1'b0);
    check_eq("loss_pllrst", pll_rst, 1'b1);
    check_eq("loss_pulse", lock_lost, 1'b1);
    check_eq("loss_relock", relock_count, 8'd1);
    tick();
    check_eq("loss_pulse_end", lock_lost, 1'b0);
    wait_for(0, 1'b0, 20, n);
    pll_locked = 1'b1;
    wait_for(1, 1'b1, 100, n);
    check_eq("relock_lat", n, ACQ);

    // Bounce during qualification
    reset_n = 1'b0;
    pll_locked = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    wait_for(0, 1'b0, 50, n);
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_for(1, 1'b1, 100, n);
    check_eq("bounce_lat", n, ACQ);
    check_eq("bounce_relock", relock_count, 8'd0);

    // Timeout loop
    reset_n = 1'b0;
    pll_locked = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    wait_for(0, 1'b0, 50, n);
    check_eq("to_first_pulse", n, PR);
    wait_for(0, 1'b1, 100, n);
    check_eq("to_wait_len", n, TO);
    check_eq("to_relock1", relock_count, 8'd1);
    wait_for(0, 1'b0, 50, n);
    check_eq("to_pulse_len", n, PR);
    wait_for(0, 1'b1, 100, n);
    check_eq("to_relock2", relock_count, 8'd2);

    // Saturation, then reset asserted during HOLD
    repeat (260 * (PR + TO)) tick();
    check_eq("relock_sat", relock_count, 8'd255);
    wait_for(0, 1'b1, 100, n);
    wait_for(0, 1'b0, 50, n);
    pll_locked = 1'b1;
    repeat (SS + 1 + LS + 1) tick();
    check_eq("hold_not_run", pll_ok, 1'b0);
    reset_n = 1'b0;
    tick();
    check_eq("midhold_reset", {20'd0, dut_vec}, {20'd0, RESET_VEC});
    reset_n = 1'b1;

    // Randomized lock activity with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        reset_n = 1'b1;
      end
      pll_locked = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 40);
      repeat (len) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
